// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write/status
// signals of the boot loader. The master modport is the byte source and
// observer side; the slave modport is the loader itself.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_wr_en;
    logic [31:0] im_wr_addr;
    logic [31:0] im_wr_data;
    logic        core_hold;
    logic        done;
    logic        err;

    modport master (
        output in_valid, in_data,
        input  in_ready, im_wr_en, im_wr_addr, im_wr_data, core_hold, done, err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, im_wr_en, im_wr_addr, im_wr_data, core_hold, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Parses a framed byte stream
// (HDR, LEN_LO, LEN_HI, 4*N big-endian payload bytes [, CSUM]), writes each
// assembled word to instruction memory at PC-domain addresses 0, PC_STEP, ...
// and keeps the core held until the whole image is loaded.
// Optional feature: define IMEM_LOADER_CSUM_EN to require a trailing XOR
// checksum byte over the payload; without it the last word goes to DONE.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned PC_STEP     = 2,
    parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
    input logic          clk,
    input logic          rst_n,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
`ifdef IMEM_LOADER_CSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    state_t      state_q;
    logic        in_ready_q;
    logic        wr_en_q;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic        hold_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [7:0]  len_lo_q;
    logic [15:0] len_q;
    logic [15:0] cnt_q;
    logic [1:0]  idx_q;
    logic [23:0] asm_q;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]  csum_q;
`endif

    logic        xfer;
    logic [15:0] len_d;
    logic [31:0] word_d;

    assign xfer   = bus.in_valid & in_ready_q;
    assign len_d  = {bus.in_data, len_lo_q};
    assign word_d = {asm_q, bus.in_data};

    assign bus.in_ready   = in_ready_q;
    assign bus.im_wr_en   = wr_en_q;
    assign bus.im_wr_addr = wr_addr_q;
    assign bus.im_wr_data = wr_data_q;
    assign bus.core_hold  = hold_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

    // Frame parser FSM with registered handshake, write strobe and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            len_lo_q   <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            asm_q      <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            // in_ready is registered, so every transition into DONE drops it below
            in_ready_q <= (state_q != DONE);
            wr_en_q    <= 1'b0;
            if (xfer) begin
                unique case (state_q)
                    IDLE, ERR: begin
                        if (bus.in_data == HDR_BYTE) begin
                            state_q <= LEN_LO;
                            err_q   <= 1'b0;
                            addr_q  <= '0;
                            cnt_q   <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                            csum_q  <= '0;
`endif
                        end
                    end
                    LEN_LO: begin
                        len_lo_q <= bus.in_data;
                        state_q  <= LEN_HI;
                    end
                    LEN_HI: begin
                        len_q <= len_d;
                        idx_q <= '0;
                        if (32'(len_d) > DEPTH_WORDS) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else if (len_d == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
                            state_q <= CSUM;
`else
                            state_q    <= DONE;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                            hold_q     <= 1'b0;
`endif
                        end else begin
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
`ifdef IMEM_LOADER_CSUM_EN
                        csum_q <= csum_q ^ bus.in_data;
`endif
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= word_d;
                            wr_addr_q <= addr_q;
                            addr_q    <= addr_q + 32'(PC_STEP);
                            cnt_q     <= cnt_q + 16'd1;
                            if (cnt_q + 16'd1 == len_q) begin
`ifdef IMEM_LOADER_CSUM_EN
                                state_q <= CSUM;
`else
                                state_q    <= DONE;
                                in_ready_q <= 1'b0;
                                done_q     <= 1'b1;
                                hold_q     <= 1'b0;
`endif
                            end
                        end else begin
                            asm_q <= {asm_q[15:0], bus.in_data};
                        end
                    end
`ifdef IMEM_LOADER_CSUM_EN
                    CSUM: begin
                        if (bus.in_data == csum_q) begin
                            state_q    <= DONE;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                            hold_q     <= 1'b0;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader. Table vectors cover
// the documented frames, hand sequences cover mid-frame reset, write latency
// and the length boundary, and random streams are checked against a
// frame-level reference model. Works with or without IMEM_LOADER_CSUM_EN.
module tb_imem_loader;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned STEP  = 2;
    localparam logic [7:0]  HDR   = 8'hA5;
`ifdef IMEM_LOADER_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    imem_loader_if bus ();

    imem_loader #(
        .DEPTH_WORDS(DEPTH),
        .PC_STEP    (STEP),
        .HDR_BYTE   (HDR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        string            nm;
        logic [191:0]     s;
        int               n;
        bit               d;
        bit               e;
        int               nw;
        logic [0:3][31:0] ea;
        logic [0:3][31:0] ed;
    } vec_t;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] stim_q[$];
    vec_t       vt[8];
    int         nv = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    bit         prev_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Write monitor: records every strobe and checks it lasts exactly one cycle
    always @(negedge clk) begin
        if (bus.im_wr_en === 1'b1) begin
            check("strobe_one_cycle", 32'(prev_en), 32'd0);
            got_q.push_back({bus.im_wr_addr, bus.im_wr_data});
        end
        prev_en = (bus.im_wr_en === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    function automatic vec_t mkv(input string nm, input logic [191:0] s, input int n,
                                 input bit d, input bit e, input int nw,
                                 input logic [0:3][31:0] ea, input logic [0:3][31:0] ed);
        vec_t v;
        v.nm = nm; v.s = s; v.n = n; v.d = d; v.e = e; v.nw = nw; v.ea = ea; v.ed = ed;
        return v;
    endfunction

    task automatic do_reset(input bit chk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        repeat (2) @(negedge clk);
        if (chk) begin
            check("rst:core_hold", 32'(bus.core_hold), 32'd1);
            check("rst:done", 32'(bus.done), 32'd0);
            check("rst:err", 32'(bus.err), 32'd0);
            check("rst:im_wr_en", 32'(bus.im_wr_en), 32'd0);
            check("rst:im_wr_addr", bus.im_wr_addr, 32'd0);
            check("rst:im_wr_data", bus.im_wr_data, 32'd0);
            check("rst:in_ready", 32'(bus.in_ready), 32'd0);
        end
        rst_n = 1'b1;
        got_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int unsigned budget = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
            end
        end
        forever begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = b;
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                break;
            end
            budget++;
            if (budget > 40) begin
                check("in_ready_wait", 32'(bus.in_ready), 32'd1);
                bus.in_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic send_stream(input bit gaps);
        foreach (stim_q[k]) send_byte(stim_q[k], gaps);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_result(input string nm, input bit d, input bit e);
        int unsigned nexp;
        repeat (4) @(negedge clk);
        check({nm, ":done"}, 32'(bus.done), 32'(d));
        check({nm, ":err"}, 32'(bus.err), 32'(e));
        check({nm, ":core_hold"}, 32'(bus.core_hold), 32'(!d));
        check({nm, ":in_ready"}, 32'(bus.in_ready), 32'(!d));
        check({nm, ":nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            check({nm, ":wr_addr"}, got_q[k].a, exp_q[k].a);
            check({nm, ":wr_data"}, got_q[k].d, exp_q[k].d);
        end
        if (d) begin
            // bytes offered while loaded must be ignored
            nexp = 32'(got_q.size());
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = HDR;
            repeat (3) @(negedge clk);
            bus.in_valid = 1'b0;
            check({nm, ":done_held"}, 32'(bus.done), 32'd1);
            check({nm, ":no_wr_after_done"}, 32'(got_q.size()), nexp);
        end
    endtask

    // Reference model: parses the stream frame by frame
    task automatic model(output bit d, output bit e);
        int unsigned i, n;
        logic [7:0]  x;
        logic [31:0] w;
        i = 0; d = 1'b0; e = 1'b0;
        exp_q.delete();
        while (i < stim_q.size() && !d) begin
            if (stim_q[i] != HDR) begin
                i++;
                continue;
            end
            if (i + 2 >= stim_q.size()) break;
            n = 32'({stim_q[i+2], stim_q[i+1]});
            i += 3;
            e = 1'b0;
            if (n > DEPTH) begin
                e = 1'b1;
                continue;
            end
            x = 8'h00;
            for (int unsigned k = 0; k < n; k++) begin
                w = {stim_q[i], stim_q[i+1], stim_q[i+2], stim_q[i+3]};
                x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
                exp_q.push_back({k * STEP, w});
                i += 4;
            end
            if (CSUM) begin
                e = (stim_q[i] != x);
                d = !e;
                i++;
            end else begin
                d = 1'b1;
            end
        end
    endtask

    task automatic push_junk();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == HDR) b = 8'h00;
        stim_q.push_back(b);
    endtask

    task automatic add_frame(input bit good);
        int unsigned n;
        logic [7:0]  x, b;
        if (!good && (!CSUM || $urandom_range(0, 1) == 0)) begin
            n = $urandom_range(DEPTH + 1, 65535);
            stim_q.push_back(HDR);
            stim_q.push_back(n[7:0]);
            stim_q.push_back(n[15:8]);
            return;
        end
        n = $urandom_range(0, 5);
        stim_q.push_back(HDR);
        stim_q.push_back(n[7:0]);
        stim_q.push_back(n[15:8]);
        x = 8'h00;
        repeat (4 * n) begin
            b = 8'($urandom);
            x = x ^ b;
            stim_q.push_back(b);
        end
        if (CSUM) stim_q.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    endtask

    initial begin
        bit d_exp, e_exp;
        int unsigned nf;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // payload XOR of 12 34 56 78 9A BC DE F0 is 00; DE AD BE EF is 22
`ifdef IMEM_LOADER_CSUM_EN
        vt[0] = mkv("good2", 192'({8'hA5,8'h02,8'h00,8'h12,8'h34,8'h56,8'h78,8'h9A,8'hBC,8'hDE,8'hF0,8'h00}),
                    12, 1, 0, 2, {32'h0, 32'h2, 32'h0, 32'h0}, {32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0});
        vt[1] = mkv("junk1", 192'({8'h00,8'hFF,8'hA5,8'h01,8'h00,8'h00,8'h00,8'h00,8'h01,8'h01}),
                    10, 1, 0, 1, {32'h0, 32'h0, 32'h0, 32'h0}, {32'h1, 32'h0, 32'h0, 32'h0});
        vt[2] = mkv("badcsum", 192'({8'hA5,8'h02,8'h00,8'h12,8'h34,8'h56,8'h78,8'h9A,8'hBC,8'hDE,8'hF0,8'h88}),
                    12, 0, 1, 2, {32'h0, 32'h2, 32'h0, 32'h0}, {32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0});
        vt[3] = mkv("bad_then_good",
                    {8'hA5,8'h02,8'h00,8'h12,8'h34,8'h56,8'h78,8'h9A,8'hBC,8'hDE,8'hF0,8'h88,
                     8'hA5,8'h02,8'h00,8'h12,8'h34,8'h56,8'h78,8'h9A,8'hBC,8'hDE,8'hF0,8'h00},
                    24, 1, 0, 4, {32'h0, 32'h2, 32'h0, 32'h2},
                    {32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0});
        vt[4] = mkv("overflow", 192'({8'hA5,8'h01,8'h01}), 3, 0, 1, 0, '0, '0);
        vt[5] = mkv("len0", 192'({8'hA5,8'h00,8'h00,8'h00}), 4, 1, 0, 0, '0, '0);
        vt[6] = mkv("ovf_then_good", 192'({8'hA5,8'h01,8'h01,8'h77,8'hA5,8'h01,8'h00,8'hDE,8'hAD,8'hBE,8'hEF,8'h22}),
                    12, 1, 0, 1, {32'h0, 32'h0, 32'h0, 32'h0}, {32'hDEADBEEF, 32'h0, 32'h0, 32'h0});
        nv = 7;
`else
        vt[0] = mkv("good2", 192'({8'hA5,8'h02,8'h00,8'h12,8'h34,8'h56,8'h78,8'h9A,8'hBC,8'hDE,8'hF0}),
                    11, 1, 0, 2, {32'h0, 32'h2, 32'h0, 32'h0}, {32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0});
        vt[1] = mkv("junk1", 192'({8'h00,8'hFF,8'hA5,8'h01,8'h00,8'h00,8'h00,8'h00,8'h01}),
                    9, 1, 0, 1, {32'h0, 32'h0, 32'h0, 32'h0}, {32'h1, 32'h0, 32'h0, 32'h0});
        vt[2] = mkv("overflow", 192'({8'hA5,8'h01,8'h01}), 3, 0, 1, 0, '0, '0);
        vt[3] = mkv("len0", 192'({8'hA5,8'h00,8'h00}), 3, 1, 0, 0, '0, '0);
        vt[4] = mkv("ovf_then_good", 192'({8'hA5,8'h01,8'h01,8'h77,8'hA5,8'h01,8'h00,8'hDE,8'hAD,8'hBE,8'hEF}),
                    11, 1, 0, 1, {32'h0, 32'h0, 32'h0, 32'h0}, {32'hDEADBEEF, 32'h0, 32'h0, 32'h0});
        vt[5] = mkv("junk_two_words", 192'({8'h11,8'h22,8'hA5,8'h02,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08}),
                    13, 1, 0, 2, {32'h0, 32'h2, 32'h0, 32'h0}, {32'h01020304, 32'h05060708, 32'h0, 32'h0});
        nv = 6;
`endif

        do_reset(1'b1);

        for (int i = 0; i < nv; i++) begin
            do_reset(1'b0);
            stim_q.delete();
            for (int k = 0; k < vt[i].n; k++) stim_q.push_back(vt[i].s[8*(vt[i].n-1-k) +: 8]);
            exp_q.delete();
            for (int w = 0; w < vt[i].nw; w++) exp_q.push_back({vt[i].ea[w], vt[i].ed[w]});
            send_stream(1'b1);
            check_result(vt[i].nm, vt[i].d, vt[i].e);
        end

        // LEN exactly DEPTH is accepted: no error, still taking payload
        do_reset(1'b0);
        send_byte(HDR, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("len_depth:err", 32'(bus.err), 32'd0);
        check("len_depth:in_ready", 32'(bus.in_ready), 32'd1);
        check("len_depth:done", 32'(bus.done), 32'd0);

        // Mid-frame reset: one word written, then abort and reload from address 0
        do_reset(1'b0);
        send_byte(HDR, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("latency:im_wr_en", 32'(bus.im_wr_en), 32'd1);
        check("latency:im_wr_addr", bus.im_wr_addr, 32'h0);
        check("latency:im_wr_data", bus.im_wr_data, 32'h12345678);
        send_byte(8'h9A, 1'b1);
        send_byte(8'hBC, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst:core_hold", 32'(bus.core_hold), 32'd1);
        check("midrst:in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst:done", 32'(bus.done), 32'd0);
        check("midrst:im_wr_en", 32'(bus.im_wr_en), 32'd0);
        check("midrst:im_wr_addr", bus.im_wr_addr, 32'h0);
        rst_n = 1'b1;
        check("midrst:nwr", 32'(got_q.size()), 32'd1);
        got_q.delete();
        stim_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        if (CSUM) stim_q.push_back(8'h01);
        exp_q.delete();
        exp_q.push_back({32'h0, 32'h1});
        send_stream(1'b1);
        check_result("reload", 1'b1, 1'b0);

        // Random streams against the frame-level model
        for (int unsigned t = 0; t < 40; t++) begin
            do_reset(1'b0);
            stim_q.delete();
            nf = $urandom_range(1, 3);
            for (int unsigned f = 0; f < nf; f++) begin
                repeat ($urandom_range(0, 2)) push_junk();
                add_frame((f + 1 == nf) && ($urandom_range(0, 4) != 0));
            end
            model(d_exp, e_exp);
            send_stream(1'b1);
            check_result("rand", d_exp, e_exp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
